// File: rtl/gda_st_err_recovery.sv
// Error detector and sequential corrector for the block-structured approximate adder:
// one DETECT cycle yields the approximate sum, then flagged blocks are re-added with the true carry.
module gda_st_err_recovery #(
  parameter int N = 8,
  parameter int R = 2,
  parameter int P = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [N-1:0]            in1,
  input  logic [N-1:0]            in2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [N:0]              approx,
  output logic [N:0]              res,
  output logic                    err,
  output logic [$clog2(N/R)-1:0]  corr_cycles
);

  localparam int B  = N / R;
  localparam int CW = $clog2(B);

  typedef enum logic [1:0] {IDLE, DETECT, CORRECT, DONE} state_t;

  state_t          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d;
  logic [N:0]      approx_q, approx_d, res_q, res_d;
  logic [CW-1:0]   corr_q, corr_d, k_q, k_d, kmax_q, kmax_d;
  logic            c_q, c_d;

  // Approximate sum, per-block mispredict flags, highest flag and block-0 carry.
  logic [N:0]      apx;
  logic [B-1:0]    flag;
  logic [CW-1:0]   kmax;
  logic            c0;

  always_comb begin
    logic [N:0] a_ext, b_ext, pw, pmask, mask, wsum, wa, wb;
    logic [R:0] blk;
    logic       pred;
    int         lo;
    apx   = '0;
    flag  = '0;
    kmax  = '0;
    c0    = 1'b0;
    a_ext = {1'b0, a_q};
    b_ext = {1'b0, b_q};
    pw    = a_ext ^ b_ext;
    pmask = ((N+1)'(1) << P) - (N+1)'(1);
    mask  = '0;
    wsum  = '0;
    wa    = '0;
    wb    = '0;
    blk   = '0;
    pred  = 1'b0;
    lo    = 0;
    for (int k = 0; k < B; k++) begin
      pred = 1'b0;
      if (k > 0) begin
        lo   = (R*k > P) ? R*k - P : 0;
        mask = ((N+1)'(1) << (R*k - lo)) - (N+1)'(1);
        wsum = ((a_ext >> lo) & mask) + ((b_ext >> lo) & mask);
        wsum = wsum >> (R*k - lo);
        pred = wsum[0];
        // A full-propagate window hides any carry arriving from below it.
        if (R*k > P && ((pw >> (R*k - P)) & pmask) == pmask) begin
          flag[k] = 1'b1;
          kmax    = CW'(k);
        end
      end
      wa  = a_ext >> (R*k);
      wb  = b_ext >> (R*k);
      blk = {1'b0, wa[R-1:0]} + {1'b0, wb[R-1:0]} + {{R{1'b0}}, pred};
      if (k == 0) c0 = blk[R];
      if (k == B-1) apx = apx | ((N+1)'(blk) << (R*k));
      else          apx = apx | ((N+1)'(blk[R-1:0]) << (R*k));
    end
  end

  // Exact re-addition of block k_q using the carry rippled so far.
  logic [N:0] a_sh, b_sh, res_fix;
  logic [R:0] cblk;

  always_comb begin
    a_sh    = {1'b0, a_q} >> (R*k_q);
    b_sh    = {1'b0, b_q} >> (R*k_q);
    cblk    = {1'b0, a_sh[R-1:0]} + {1'b0, b_sh[R-1:0]} + {{R{1'b0}}, c_q};
    res_fix = (res_q & ~((N+1)'({R{1'b1}}) << (R*k_q)))
            | ((N+1)'(cblk[R-1:0]) << (R*k_q));
    if (k_q == CW'(B-1)) res_fix[N] = cblk[R];
  end

  always_comb begin
    // NOTE: every _d takes its _q value first so no path through the case infers a latch.
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    approx_d = approx_q;
    res_d    = res_q;
    corr_d   = corr_q;
    k_d      = k_q;
    kmax_d   = kmax_q;
    c_d      = c_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = in1;
          b_d     = in2;
          state_d = DETECT;
        end
      end
      DETECT: begin
        approx_d = apx;
        res_d    = apx;
        corr_d   = '0;
        if (flag == '0) begin
          state_d = DONE;
        end else begin
          k_d     = CW'(1);
          c_d     = c0;
          kmax_d  = kmax;
          state_d = CORRECT;
        end
      end
      CORRECT: begin
        res_d  = res_fix;
        c_d    = cblk[R];
        corr_d = corr_q + CW'(1);
        if (k_q == kmax_q) state_d = DONE;
        else               k_d     = k_q + CW'(1);
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only; every register is cleared on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      approx_q <= '0;
      res_q    <= '0;
      corr_q   <= '0;
      k_q      <= '0;
      kmax_q   <= '0;
      c_q      <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      approx_q <= approx_d;
      res_q    <= res_d;
      corr_q   <= corr_d;
      k_q      <= k_d;
      kmax_q   <= kmax_d;
      c_q      <= c_d;
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = (state_q == DONE);
  assign approx      = approx_q;
  assign res         = res_q;
  assign corr_cycles = corr_q;
  assign err         = out_valid && (res_q != approx_q);

endmodule

// File: tb/tb_gda_st_err_recovery.sv
// Scoreboard bench for gda_st_err_recovery: the driver queues expected results, a negedge
// monitor checks latency on out_valid rise and the result fields on each handshake.
module tb_gda_st_err_recovery;

  localparam int N  = 8;
  localparam int R  = 2;
  localparam int P  = 4;
  localparam int B  = N / R;
  localparam int CW = $clog2(B);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in1, in2;
  logic          out_valid;
  logic          out_ready;
  logic [N:0]    approx, res;
  logic          err;
  logic [CW-1:0] corr_cycles;

  gda_st_err_recovery #(.N(N), .R(R), .P(P)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in1(in1), .in2(in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .approx(approx), .res(res), .err(err), .corr_cycles(corr_cycles)
  );

  always #5 clk = ~clk;

  typedef struct {
    int approx;
    int res;
    int err;
    int corr;
    int lat;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   neg_cnt  = 0;
  int   t_acc    = 0;
  bit   ov_seen  = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference approximate adder written straight from the block/window definition.
  function automatic int approx_model(input int a, input int b);
    int r, lo, w, pred, s;
    r = 0;
    for (int k = 0; k < B; k++) begin
      pred = 0;
      if (k > 0) begin
        lo   = (R*k - P > 0) ? R*k - P : 0;
        w    = R*k - lo;
        pred = ((((a >> lo) & ((1 << w) - 1)) + ((b >> lo) & ((1 << w) - 1))) >> w) & 1;
      end
      s = ((a >> (R*k)) & ((1 << R) - 1)) + ((b >> (R*k)) & ((1 << R) - 1)) + pred;
      if (k < B-1) s = s & ((1 << R) - 1);
      r = r | (s << (R*k));
    end
    return r;
  endfunction

  function automatic int kmax_model(input int a, input int b);
    int p, km;
    p  = a ^ b;
    km = 0;
    for (int k = 1; k < B; k++)
      if (R*k - P > 0 && ((p >> (R*k - P)) & ((1 << P) - 1)) == (1 << P) - 1) km = k;
    return km;
  endfunction

  always @(negedge clk) begin
    neg_cnt++;
    if (in_valid && in_ready) t_acc = neg_cnt;
    if (!out_valid) begin
      ov_seen = 1'b0;
    end else if (sb.size() == 0) begin
      check("spurious_out_valid", int'(out_valid), 0);
    end else begin
      if (!ov_seen) begin
        check("latency", neg_cnt - t_acc, sb[0].lat);
        ov_seen = 1'b1;
      end
      if (out_ready) begin
        exp_t e;
        e = sb.pop_front();
        check("approx", int'(approx), e.approx);
        check("res", int'(res), e.res);
        check("err", int'(err), e.err);
        check("corr_cycles", int'(corr_cycles), e.corr);
      end
    end
  end

  task automatic issue(input int a, input int b, input int exp_apx, input int exp_res, input int exp_corr);
    exp_t e;
    e.approx = exp_apx;
    e.res    = exp_res;
    e.err    = (exp_apx != exp_res) ? 1 : 0;
    e.corr   = exp_corr;
    e.lat    = 2 + exp_corr;
    @(posedge clk);
    #1;
    in1      = N'(a);
    in2      = N'(b);
    in_valid = 1'b1;
    sb.push_back(e);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (in_ready) break;
    end
    if (!in_ready) check("accept_timeout", int'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      check("drain_timeout", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_in_ready"}, int'(in_ready), 1);
    check({tag, "_out_valid"}, int'(out_valid), 0);
    check({tag, "_approx"}, int'(approx), 0);
    check({tag, "_res"}, int'(res), 0);
    check({tag, "_err"}, int'(err), 0);
    check({tag, "_corr"}, int'(corr_cycles), 0);
  endtask

  initial begin
    int a, b, apx, km;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in1       = '0;
    in2       = '0;
    out_ready = 1'b1;
    #3;
    check_idle_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors
    issue(8'h12, 8'h34, 9'h046, 9'h046, 0); wait_drain();
    issue(8'h3F, 8'h01, 9'h000, 9'h040, 3); wait_drain();
    issue(8'hFF, 8'hFF, 9'h1FE, 9'h1FE, 0); wait_drain();
    issue(8'h00, 8'h00, 9'h000, 9'h000, 0); wait_drain();
    issue(8'hFF, 8'h01, 9'h0C0, 9'h100, 3); wait_drain();
    issue(8'h3C, 8'h00, 9'h03C, 9'h03C, 3); wait_drain();

    // Back-pressure: result held for 4 cycles, an in_valid pulse in the stall is dropped
    out_ready = 1'b0;
    issue(8'h3F, 8'h01, 9'h000, 9'h040, 3);
    for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      if (i == 1) begin
        in1      = 8'h12;
        in2      = 8'h34;
        in_valid = 1'b1;
      end
      if (i == 2) in_valid = 1'b0;
      @(negedge clk);
      check("stall_out_valid", int'(out_valid), 1);
      check("stall_in_ready", int'(in_ready), 0);
      check("stall_approx", int'(approx), 9'h000);
      check("stall_res", int'(res), 9'h040);
      check("stall_err", int'(err), 1);
      check("stall_corr", int'(corr_cycles), 3);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_in_ready", int'(in_ready), 1);
    check("release_out_valid", int'(out_valid), 0);
    repeat (3) @(posedge clk);
    #1;
    check("dropped_in_ready", int'(in_ready), 1);
    wait_drain();

    // Asynchronous reset during the second CORRECT cycle
    issue(8'h3F, 8'h01, 9'h000, 9'h040, 3);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("midrst");
    sb.delete();
    @(posedge clk);
    #3;
    rst_n = 1'b1;
    issue(8'h12, 8'h34, 9'h046, 9'h046, 0); wait_drain();

    // Random pairs against the model
    for (int n = 0; n < 3000; n++) begin
      a   = int'($urandom_range(0, 255));
      b   = int'($urandom_range(0, 255));
      apx = approx_model(a, b);
      km  = kmax_model(a, b);
      issue(a, b, apx, a + b, km);
      wait_drain();
    end

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
